// File: rtl/bram_rport_frontend.sv
// Two-port read front end for a 2R1W BRAM: valid/ready requests, registered-read capture, per-port response FIFO.
// Optional same-cycle write forwarding is enabled by defining BRAM_RPORT_WRITE_BYPASS_EN.

module bram_rport_frontend_port #(
  parameter int unsigned INNER_WIDTH = 32,
  parameter int unsigned OUTER_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH  = 4,
  localparam int unsigned IW = $clog2(OUTER_WIDTH),
  localparam int unsigned BW = INNER_WIDTH / 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [IW-1:0]          i_req_index,
  output logic                   o_resp_valid,
  input  logic                   i_resp_ready,
  output logic [INNER_WIDTH-1:0] o_resp_data,
  output logic                   o_ren,
  output logic [IW-1:0]          o_rindex,
  input  logic [INNER_WIDTH-1:0] i_rdata,
  input  logic [BW-1:0]          i_snoop_wen_byte,
  input  logic [IW-1:0]          i_snoop_windex,
  input  logic [INNER_WIDTH-1:0] i_snoop_wdata
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [CW-1:0]          r_count;
  logic                   r_inflight;
  logic [PW-1:0]          r_head;
  logic [PW-1:0]          r_tail;
  logic [INNER_WIDTH-1:0] r_mem [FIFO_DEPTH];

  logic [CW-1:0]          w_credit;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_pop;
  logic [INNER_WIDTH-1:0] w_push_data;

  // Credit counts the in-flight read so its push can never overflow the FIFO.
  assign w_credit     = r_count + CW'(r_inflight);
  assign o_req_ready  = !i_rst && (w_credit < CW'(FIFO_DEPTH));
  assign w_accept     = i_req_valid & o_req_ready;
  assign o_ren        = w_accept;
  assign o_rindex     = i_req_index;

  assign w_push       = r_inflight;
  assign o_resp_valid = (r_count != '0);
  assign w_pop        = o_resp_valid & i_resp_ready;
  assign o_resp_data  = o_resp_valid ? r_mem[r_head] : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_inflight <= w_accept;
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_tail] <= w_push_data;
  end

`ifdef BRAM_RPORT_WRITE_BYPASS_EN
  logic [BW-1:0]          r_byp_mask;
  logic [INNER_WIDTH-1:0] r_byp_data;

  // Mask is only consumed in the cycle after an accept, so it is refreshed on accepts alone.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_byp_mask <= '0;
      r_byp_data <= '0;
    end else if (w_accept) begin
      r_byp_mask <= (i_snoop_windex == i_req_index) ? i_snoop_wen_byte : '0;
      r_byp_data <= i_snoop_wdata;
    end
  end

  always_comb begin
    w_push_data = i_rdata;
    for (int unsigned b = 0; b < BW; b++) begin
      if (r_byp_mask[b]) w_push_data[8*b +: 8] = r_byp_data[8*b +: 8];
    end
  end
`else
  logic w_unused_snoop;
  assign w_unused_snoop = ^{i_snoop_wen_byte, i_snoop_windex, i_snoop_wdata};
  assign w_push_data    = i_rdata;
`endif

endmodule

module bram_rport_frontend #(
  parameter int unsigned INNER_WIDTH = 32,
  parameter int unsigned OUTER_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH  = 4,
  localparam int unsigned IW = $clog2(OUTER_WIDTH),
  localparam int unsigned BW = INNER_WIDTH / 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [IW-1:0]          req0_index,
  output logic                   resp0_valid,
  input  logic                   resp0_ready,
  output logic [INNER_WIDTH-1:0] resp0_data,
  output logic                   bram_port0_ren,
  output logic [IW-1:0]          bram_port0_rindex,
  input  logic [INNER_WIDTH-1:0] bram_port0_rdata,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [IW-1:0]          req1_index,
  output logic                   resp1_valid,
  input  logic                   resp1_ready,
  output logic [INNER_WIDTH-1:0] resp1_data,
  output logic                   bram_port1_ren,
  output logic [IW-1:0]          bram_port1_rindex,
  input  logic [INNER_WIDTH-1:0] bram_port1_rdata,
  input  logic [BW-1:0]          snoop_wen_byte,
  input  logic [IW-1:0]          snoop_windex,
  input  logic [INNER_WIDTH-1:0] snoop_wdata
);

  bram_rport_frontend_port #(
    .INNER_WIDTH (INNER_WIDTH),
    .OUTER_WIDTH (OUTER_WIDTH),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) u_port0 (
    .i_clk            (CLK),
    .i_rst            (RST),
    .i_req_valid      (req0_valid),
    .o_req_ready      (req0_ready),
    .i_req_index      (req0_index),
    .o_resp_valid     (resp0_valid),
    .i_resp_ready     (resp0_ready),
    .o_resp_data      (resp0_data),
    .o_ren            (bram_port0_ren),
    .o_rindex         (bram_port0_rindex),
    .i_rdata          (bram_port0_rdata),
    .i_snoop_wen_byte (snoop_wen_byte),
    .i_snoop_windex   (snoop_windex),
    .i_snoop_wdata    (snoop_wdata)
  );

  bram_rport_frontend_port #(
    .INNER_WIDTH (INNER_WIDTH),
    .OUTER_WIDTH (OUTER_WIDTH),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) u_port1 (
    .i_clk            (CLK),
    .i_rst            (RST),
    .i_req_valid      (req1_valid),
    .o_req_ready      (req1_ready),
    .i_req_index      (req1_index),
    .o_resp_valid     (resp1_valid),
    .i_resp_ready     (resp1_ready),
    .o_resp_data      (resp1_data),
    .o_ren            (bram_port1_ren),
    .o_rindex         (bram_port1_rindex),
    .i_rdata          (bram_port1_rdata),
    .i_snoop_wen_byte (snoop_wen_byte),
    .i_snoop_windex   (snoop_windex),
    .i_snoop_wdata    (snoop_wdata)
  );

endmodule

// File: tb/tb_bram_rport_frontend.sv
// Bench for bram_rport_frontend: BRAM model, directed vector table, hand sequences, randomized run vs. a
// transaction-level reference (outstanding-request queues per port).

module tb_bram_rport_frontend;

  localparam int unsigned DW = 32;
  localparam int unsigned OW = 32;
  localparam int unsigned FD = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req0_valid, req0_ready, resp0_valid, resp0_ready, bram_port0_ren;
  logic        req1_valid, req1_ready, resp1_valid, resp1_ready, bram_port1_ren;
  logic [4:0]  req0_index, req1_index, bram_port0_rindex, bram_port1_rindex;
  logic [31:0] resp0_data, resp1_data;
  logic [31:0] bram_port0_rdata = '0;
  logic [31:0] bram_port1_rdata = '0;
  logic [3:0]  snoop_wen_byte;
  logic [4:0]  snoop_windex;
  logic [31:0] snoop_wdata;

  always #5 CLK = ~CLK;

  bram_rport_frontend #(
    .INNER_WIDTH (DW),
    .OUTER_WIDTH (OW),
    .FIFO_DEPTH  (FD)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
    .req0_valid        (req0_valid),
    .req0_ready        (req0_ready),
    .req0_index        (req0_index),
    .resp0_valid       (resp0_valid),
    .resp0_ready       (resp0_ready),
    .resp0_data        (resp0_data),
    .bram_port0_ren    (bram_port0_ren),
    .bram_port0_rindex (bram_port0_rindex),
    .bram_port0_rdata  (bram_port0_rdata),
    .req1_valid        (req1_valid),
    .req1_ready        (req1_ready),
    .req1_index        (req1_index),
    .resp1_valid       (resp1_valid),
    .resp1_ready       (resp1_ready),
    .resp1_data        (resp1_data),
    .bram_port1_ren    (bram_port1_ren),
    .bram_port1_rindex (bram_port1_rindex),
    .bram_port1_rdata  (bram_port1_rdata),
    .snoop_wen_byte    (snoop_wen_byte),
    .snoop_windex      (snoop_windex),
    .snoop_wdata       (snoop_wdata)
  );

  // BRAM environment: registered reads, byte-enabled writes, read-before-write.
  logic [31:0] mem [OW];
  always @(posedge CLK) begin
    if (bram_port0_ren) bram_port0_rdata <= mem[bram_port0_rindex];
    if (bram_port1_ren) bram_port1_rdata <= mem[bram_port1_rindex];
    for (int b = 0; b < 4; b++)
      if (snoop_wen_byte[b]) mem[snoop_windex][8*b +: 8] <= snoop_wdata[8*b +: 8];
  end

  // Reference: per port, the list of accepted-but-not-consumed requests with data and accept cycle.
  logic [31:0] md [2][256];
  int          mc [2][256];
  int          mh [2];
  int          mt [2];
  int          cyc;
  int          n_chk;
  int          n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] init_val(input int i);
    if (i == 5) return 32'hDEADBEEF;
    if (i == 7) return 32'h11223344;
    return 32'hC0DE0000 + i;
  endfunction

  function automatic logic [31:0] read_value(input logic [4:0] idx);
    logic [31:0] m;
    m = mem[idx];
`ifdef BRAM_RPORT_WRITE_BYPASS_EN
    if (snoop_windex == idx)
      for (int b = 0; b < 4; b++)
        if (snoop_wen_byte[b]) m[8*b +: 8] = snoop_wdata[8*b +: 8];
`endif
    return m;
  endfunction

  task automatic step(input logic v0, input logic [4:0] x0, input logic r0,
                      input logic v1, input logic [4:0] x1, input logic r1,
                      input logic [3:0] we, input logic [4:0] wx, input logic [31:0] wd,
                      input logic rst);
    logic       lv [2];
    logic [4:0] lx [2];
    logic       lr [2];
    logic       e_rdy, e_rv, e_ren;
    int         outst;
    RST = rst;
    req0_valid = v0; req0_index = x0; resp0_ready = r0;
    req1_valid = v1; req1_index = x1; resp1_ready = r1;
    snoop_wen_byte = we; snoop_windex = wx; snoop_wdata = wd;
    lv[0] = v0; lx[0] = x0; lr[0] = r0;
    lv[1] = v1; lx[1] = x1; lr[1] = r1;
    #1;
    for (int p = 0; p < 2; p++) begin
      outst = mt[p] - mh[p];
      e_rdy = !rst && (outst < FD);
      e_rv  = !rst && (outst > 0) && (mc[p][mh[p] & 255] <= cyc - 2);
      e_ren = lv[p] && e_rdy;
      chk($sformatf("p%0d_req_ready", p), p == 0 ? req0_ready : req1_ready, e_rdy);
      chk($sformatf("p%0d_resp_valid", p), p == 0 ? resp0_valid : resp1_valid, e_rv);
      chk($sformatf("p%0d_ren", p), p == 0 ? bram_port0_ren : bram_port1_ren, e_ren);
      if (e_ren)
        chk($sformatf("p%0d_rindex", p), p == 0 ? bram_port0_rindex : bram_port1_rindex, lx[p]);
      if (e_rv)
        chk($sformatf("p%0d_resp_data", p), p == 0 ? resp0_data : resp1_data, md[p][mh[p] & 255]);
      if (rst)
        chk($sformatf("p%0d_resp_data_rst", p), p == 0 ? resp0_data : resp1_data, 32'h0);
      if (rst) begin
        mh[p] = 0; mt[p] = 0;
      end else begin
        if (e_ren) begin
          md[p][mt[p] & 255] = read_value(lx[p]);
          mc[p][mt[p] & 255] = cyc;
          mt[p]++;
        end
        if (e_rv && lr[p]) mh[p]++;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
  endtask

  typedef struct {
    logic v; logic [4:0] x; logic rr;
    logic [3:0] we; logic [4:0] wx; logic [31:0] wd;
    logic e_rdy; logic e_ren; logic e_rv; logic [31:0] e_d;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [4:0] x, input logic rr,
                              input logic [3:0] we, input logic [4:0] wx, input logic [31:0] wd,
                              input logic e_rdy, input logic e_ren, input logic e_rv,
                              input logic [31:0] e_d);
    vec_t t;
    t.v = v; t.x = x; t.rr = rr; t.we = we; t.wx = wx; t.wd = wd;
    t.e_rdy = e_rdy; t.e_ren = e_ren; t.e_rv = e_rv; t.e_d = e_d;
    return t;
  endfunction

  vec_t        tbl [21];
  logic [31:0] byp_exp;

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    mh[0] = 0; mh[1] = 0; mt[0] = 0; mt[1] = 0;
    RST = 1'b1;
    req0_valid = 0; req0_index = 0; resp0_ready = 0;
    req1_valid = 0; req1_index = 0; resp1_ready = 0;
    snoop_wen_byte = 0; snoop_windex = 0; snoop_wdata = 0;

`ifdef BRAM_RPORT_WRITE_BYPASS_EN
    byp_exp = 32'h1122CCDD;
`else
    byp_exp = 32'h11223344;
`endif
    //              v  x  rr we    wx wd            rdy ren rv data
    tbl[0]  = mk(1, 5, 1, 0,    0, 0,            1, 1, 0, 0);
    tbl[1]  = mk(0, 0, 1, 0,    0, 0,            1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 0,    0, 0,            1, 0, 1, 32'hDEADBEEF);
    tbl[3]  = mk(0, 0, 0, 0,    0, 0,            1, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0,    0, 0,            1, 1, 0, 0);
    tbl[5]  = mk(1, 1, 0, 0,    0, 0,            1, 1, 0, 0);
    tbl[6]  = mk(1, 2, 0, 0,    0, 0,            1, 1, 1, 32'hC0DE0000);
    tbl[7]  = mk(1, 3, 0, 0,    0, 0,            1, 1, 1, 32'hC0DE0000);
    tbl[8]  = mk(1, 4, 0, 0,    0, 0,            0, 0, 1, 32'hC0DE0000);
    tbl[9]  = mk(1, 4, 0, 0,    0, 0,            0, 0, 1, 32'hC0DE0000);
    tbl[10] = mk(1, 4, 1, 0,    0, 0,            0, 0, 1, 32'hC0DE0000);
    tbl[11] = mk(1, 4, 0, 0,    0, 0,            1, 1, 1, 32'hC0DE0001);
    tbl[12] = mk(0, 0, 1, 0,    0, 0,            0, 0, 1, 32'hC0DE0001);
    tbl[13] = mk(0, 0, 1, 0,    0, 0,            1, 0, 1, 32'hC0DE0002);
    tbl[14] = mk(0, 0, 1, 0,    0, 0,            1, 0, 1, 32'hC0DE0003);
    tbl[15] = mk(0, 0, 1, 0,    0, 0,            1, 0, 1, 32'hC0DE0004);
    tbl[16] = mk(0, 0, 1, 0,    0, 0,            1, 0, 0, 0);
    tbl[17] = mk(1, 7, 1, 4'h3, 7, 32'hAABBCCDD, 1, 1, 0, 0);
    tbl[18] = mk(0, 0, 1, 0,    0, 0,            1, 0, 0, 0);
    tbl[19] = mk(0, 0, 1, 0,    0, 0,            1, 0, 1, byp_exp);
    tbl[20] = mk(0, 0, 1, 0,    0, 0,            1, 0, 0, 0);

    @(negedge CLK);
    // Load the BRAM through its write port while the front end is held in reset.
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 0, 0, 0, 4'hF, 5'(i), init_val(i), 1);
      tick();
    end

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].v, tbl[i].x, tbl[i].rr, 0, 0, 0, tbl[i].we, tbl[i].wx, tbl[i].wd, 0);
      chk($sformatf("tbl%0d_ready", i), req0_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_ren", i), bram_port0_ren, tbl[i].e_ren);
      if (tbl[i].e_ren) chk($sformatf("tbl%0d_rindex", i), bram_port0_rindex, tbl[i].x);
      chk($sformatf("tbl%0d_resp_valid", i), resp0_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) chk($sformatf("tbl%0d_resp_data", i), resp0_data, tbl[i].e_d);
      tick();
    end

    // Both ports streaming back-to-back, then port 1 streaming while port 0 stalls.
    for (int k = 0; k < 16; k++) begin
      step(1, 5'(k), 1, 1, 5'(k), 1, 0, 0, 0, 0);
      chk("stream_ren0", bram_port0_ren, 1'b1);
      chk("stream_ren1", bram_port1_ren, 1'b1);
      tick();
    end
    for (int k = 0; k < 16; k++) begin
      step(1, 5'(k), 0, 1, 5'(15 - k), 1, 0, 0, 0, 0);
      chk("stall_ren1", bram_port1_ren, 1'b1);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
      tick();
    end

    // Reset with two entries held and a read in flight.
    step(1, 8, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    step(1, 9, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    step(1, 10, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    step(1, 11, 1, 1, 3, 1, 0, 0, 0, 1);
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_valid0", resp0_valid, 1'b0);
    chk("rst_ren0", bram_port0_ren, 1'b0);
    chk("rst_data0", resp0_data, 32'h0);
    tick();
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
      chk("post_rst_no_stale", resp0_valid, 1'b0);
      tick();
    end
    step(1, 12, 1, 0, 0, 1, 0, 0, 0, 0); tick();
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
      tick();
    end

    // Randomized traffic with writes that often collide with the requested index.
    for (int k = 0; k < 3000; k++) begin
      logic       v0, v1, r0, r1;
      logic [4:0] x0, x1, wx;
      logic [3:0] we;
      int         bias;
      bias = ((k / 400) % 2 == 1) ? 25 : 90;
      v0 = ($urandom_range(0, 99) < 70);
      v1 = ($urandom_range(0, 99) < 70);
      r0 = ($urandom_range(0, 99) < bias);
      r1 = ($urandom_range(0, 99) < 60);
      x0 = 5'($urandom_range(0, 31));
      x1 = ($urandom_range(0, 3) == 0) ? x0 : 5'($urandom_range(0, 31));
      we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
      case ($urandom_range(0, 2))
        0:       wx = x0;
        1:       wx = x1;
        default: wx = 5'($urandom_range(0, 31));
      endcase
      step(v0, x0, r0, v1, x1, r1, we, wx, $urandom, 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
